// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the Hack ROM loader.
// The loader takes the slave view; the byte source / ROM side takes the master view.
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic                  rom_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, rom_addr, rom_data, rom_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, rom_addr, rom_data, rom_we
  );
endinterface

// File: rtl/rom_loader.sv
// Fills the Hack instruction ROM from a length-prefixed big-endian byte stream,
// holding the CPU in reset until the whole program has been written.
module rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        reset,
  rom_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  // Seventeen bits so a 16-bit ADDR_WIDTH still has a representable capacity.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            len_hi;
  logic [7:0]            data_hi;
  logic [15:0]           len;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  accept;
  logic [15:0]           full_len;

  assign accept   = bus.in_valid && bus.in_ready;
  assign full_len = {len_hi, bus.in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LEN_HI;
      len_hi       <= 8'd0;
      data_hi      <= 8'd0;
      len          <= 16'd0;
      addr_cnt     <= '0;
      bus.in_ready <= 1'b1;
      bus.rom_addr <= '0;
      bus.rom_data <= 16'd0;
      bus.rom_we   <= 1'b0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      word_count   <= 16'd0;
    end else begin
      bus.rom_we <= 1'b0;
      case (state)
        LEN_HI: begin
          if (accept) begin
            len_hi <= bus.in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len <= full_len;
            if (full_len == 16'd0) begin
              state        <= FLUSH;
              bus.in_ready <= 1'b0;
            end else if ({1'b0, full_len} > CAPACITY) begin
              state        <= ERROR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            data_hi <= bus.in_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          // A full-capacity program wraps addr_cnt back to 0 with no extra write.
          if (accept) begin
            bus.rom_data <= {data_hi, bus.in_data};
            bus.rom_addr <= addr_cnt;
            bus.rom_we   <= 1'b1;
            addr_cnt     <= addr_cnt + ADDR_WIDTH'(1);
            word_count   <= word_count + 16'd1;
            if (word_count + 16'd1 == len) begin
              state        <= FLUSH;
              bus.in_ready <= 1'b0;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        FLUSH: begin
          state     <= DONE;
          done      <= 1'b1;
          cpu_reset <= 1'b0;
        end
        DONE: begin
        end
        ERROR: begin
        end
        default: begin
          state        <= ERROR;
          bus.in_ready <= 1'b0;
          error        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the Hack instruction ROM. The program counter only reads the ROM; this block fills it.
- Receives a byte stream, assembles big-endian 16-bit instruction words and writes them to consecutive ROM addresses starting at 0.
- Holds the CPU in reset until the whole program is written, then releases it so the PC starts fetching at address 0.

Parameters:
- ADDR_WIDTH, 15, ROM address width; capacity is 2^ADDR_WIDTH words (32768 by default).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- rom_addr  output  ADDR_WIDTH  ROM write address.
- rom_data  output  16  ROM write data.
- rom_we  output  1  ROM write strobe, one cycle per word.
- cpu_reset  output  1  drives the CPU and PC reset.
- done  output  1  program fully written.
- error  output  1  header length exceeded capacity.
- word_count  output  16  words written so far.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on the port named reset.
- Byte accept: a byte is consumed on a rising edge where in_valid && in_ready. No other condition consumes a byte.
- Stream format:
  - Two-byte length header L, high byte first.
  - Then L words, each sent high byte first.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, FLUSH, DONE, ERROR.
- Reset (synchronous, wins over all other activity, including mid-stream):
  - state=LEN_HI, in_ready=1, rom_we=0, rom_addr=0, rom_data=0.
  - cpu_reset=1, done=0, error=0, word_count=0.
  - Internal address counter=0; any partial header or word is discarded.
- LEN_HI, on accept: latch L[15:8]; go to LEN_LO.
- LEN_LO, on accept: latch L[7:0], then branch on the full L:
  - L==0: go to FLUSH.
  - L>2^ADDR_WIDTH: go to ERROR.
  - Otherwise: go to DATA_HI.
- DATA_HI, on accept: latch the high byte; go to DATA_LO.
- DATA_LO, on accept:
  - Register rom_data={hi,in_data}, rom_addr=counter and rom_we=1, all visible in the cycle after the edge.
  - Counter and word_count increment on the same edge.
  - If word_count+1==L, go to FLUSH; otherwise go to DATA_HI.
- rom_we is a single-cycle pulse: it clears on the next edge unless another word completes on that edge. Back-to-back completion is impossible because each word needs 2 accepts.
- FLUSH:
  - in_ready=0.
  - Exactly one cycle, which covers the final rom_we pulse.
  - Next edge: go to DONE.
- DONE:
  - in_ready=0, cpu_reset=0, done=1.
  - Held until reset; further input is ignored.
  - cpu_reset therefore never falls in the same cycle as any rom_we.
- ERROR:
  - in_ready=0, error=1, cpu_reset=1, done=0, rom_we=0.
  - Held until reset.
- in_ready=1 in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- in_valid low while in_ready is high stalls the loader indefinitely without state change.
- rom_addr and rom_data hold their last values when rom_we=0.
- Counter wrap: L==2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH-1 and the counter wraps to 0 internally with no further write. word_count is 16 bits and records 32768.
- Latency:
  - Last data byte accepted at edge N.
  - rom_we high during cycle N→N+1.
  - FLUSH during N→N+1.
  - done=1 and cpu_reset=0 from edge N+1.

Test Plan:
- Reset then bytes 00 03 00 2F 02 0F FF FF with in_valid held high:
  - rom_we pulses 3 times with (addr,data) = (0,0x002F), (1,0x020F), (2,0xFFFF).
  - done=1 and cpu_reset=0 exactly one cycle after the last pulse.
  - word_count=3.
- Header 00 00:
  - No rom_we.
  - done=1 two edges after the second header byte.
  - in_ready=0 afterwards; extra bytes ignored.
- Header 80 01 with ADDR_WIDTH=15:
  - error=1, cpu_reset stays 1, in_ready=0, no rom_we.
  - Reset clears error.
- Stall: send 00 02 12, then in_valid=0 for 5 cycles, then 34 56 78:
  - No state change during the stall.
  - Writes (0,0x1234) then (1,0x5678).
- Reset mid-operation: assert reset after 00 04 AB CD EF:
  - Only write (0,0xABCD) occurs.
  - After reset, outputs return to reset values.
  - A fresh stream 00 01 11 22 writes (0,0x1122) and reaches done.
- Simultaneous reset and valid byte on the same edge:
  - Reset wins; the byte is not consumed; state=LEN_HI.
